// File: rtl/kamikaze_decode_pkg.sv
// Shared constants for the kamikaze decode stage: ALU function codes, opcodes,
// and the funct3 legality helper also used by the execute stage.
package kamikaze_decode_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_XOR = 3'b100,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_func_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;

  // funct3 doubles as the ALU function code, so only the four ALU codes are legal.
  function automatic logic func_supported(input logic [2:0] funct3);
    return (funct3 == ALU_ADD) || (funct3 == ALU_XOR) ||
           (funct3 == ALU_OR)  || (funct3 == ALU_AND);
  endfunction

endpackage

// File: rtl/kamikaze_decode_scoreboard.sv
// Busy-bit scoreboard for the kamikaze decode stage: one bit per architectural
// register, set on issue, cleared by writeback or flush, two hazard lookups.
module kamikaze_scoreboard
  import kamikaze_decode_pkg::*;
#(
  parameter int RF_AW = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_en,
  input  logic [RF_AW-1:0] set_rd,
  input  logic             clr_en,
  input  logic [RF_AW-1:0] clr_rd,
  input  logic             flush_en,
  input  logic [RF_AW-1:0] flush_rd,
  input  logic [RF_AW-1:0] rs1,
  input  logic [RF_AW-1:0] rs2,
  output logic             busy1,
  output logic             busy2
);

  localparam int NREG = 1 << RF_AW;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    busy_next = busy;
    if (clr_en)   busy_next[clr_rd]   = 1'b0;
    if (flush_en) busy_next[flush_rd] = 1'b0;
    // Applied last so an issue wins over a same-cycle clear of that register.
    if (set_en)   busy_next[set_rd]   = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: the busy array is small state that must start empty, so unlike a
  // RAM it is reset in full rather than left uninitialised.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) busy <= '0;
    else        busy <= busy_next;
  end

  assign busy1 = busy[rs1];
  assign busy2 = busy[rs2];

endmodule

// File: rtl/kamikaze_decode.sv
// Decode stage of the kamikaze RV32 pipeline with RAW interlock scoreboard.
// Define KAMIKAZE_UIMM_EN to decode LUI and AUIPC; otherwise they are illegal.
module kamikaze_decode
  import kamikaze_decode_pkg::*;
#(
  parameter int RF_AW = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      pc_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [RF_AW-1:0] rf_raddr1_o,
  output logic [RF_AW-1:0] rf_raddr2_o,
  input  logic [31:0]      rf_rdata1_i,
  input  logic [31:0]      rf_rdata2_i,
  input  logic             wb_valid_i,
  input  logic [RF_AW-1:0] wb_rd_i,
  input  logic             flush_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [31:0]      alu_op1_o,
  output logic             alu_op2_sel_o,
  output logic [31:0]      alu_op2_o,
  output logic [31:0]      alu_op2_imm_o,
  output logic [2:0]       alu_func_o,
  output logic [RF_AW-1:0] rd_o,
  output logic [31:0]      pc_o,
  output logic             illegal_o
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [RF_AW-1:0] rd;

  logic        is_legal;
  logic        rs1_used;
  logic        rs2_used;
  logic        dec_sel;
  logic [31:0] dec_op1;
  logic [31:0] dec_imm;
  logic [2:0]  dec_func;

  logic busy1;
  logic busy2;
  logic hazard;
  logic load;
  logic issue;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign funct7      = inst_i[31:25];
  assign rd          = inst_i[7 +: RF_AW];
  assign rf_raddr1_o = inst_i[15 +: RF_AW];
  assign rf_raddr2_o = inst_i[20 +: RF_AW];

  always_comb begin
    is_legal = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    dec_sel  = 1'b0;
    dec_op1  = rf_rdata1_i;
    dec_imm  = {{20{inst_i[31]}}, inst_i[31:20]};
    dec_func = funct3;
    case (opcode)
      OPC_OP_IMM: begin
        is_legal = func_supported(funct3);
        rs1_used = 1'b1;
      end
      OPC_OP: begin
        is_legal = func_supported(funct3) && (funct7 == F7_BASE);
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        dec_sel  = 1'b1;
      end
`ifdef KAMIKAZE_UIMM_EN
      OPC_LUI: begin
        is_legal = 1'b1;
        dec_op1  = '0;
        dec_imm  = {inst_i[31:12], 12'b0};
        dec_func = ALU_ADD;
      end
      OPC_AUIPC: begin
        is_legal = 1'b1;
        dec_op1  = pc_i;
        dec_imm  = {inst_i[31:12], 12'b0};
        dec_func = ALU_ADD;
      end
`endif
      default: ;
    endcase
  end

  // Illegal instructions never stall: they are consumed and dropped.
  assign hazard  = valid_i && is_legal &&
                   ((rs1_used && busy1) || (rs2_used && busy2));
  assign ready_o = (!valid_o || ready_i) && !hazard && !flush_i;
  assign load    = valid_i && ready_o;
  assign issue   = load && is_legal;

  kamikaze_scoreboard #(.RF_AW(RF_AW)) u_scoreboard (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_en   (issue),
    .set_rd   (rd),
    .clr_en   (wb_valid_i),
    .clr_rd   (wb_rd_i),
    .flush_en (flush_i && valid_o),
    .flush_rd (rd_o),
    .rs1      (rf_raddr1_o),
    .rs2      (rf_raddr2_o),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o       <= 1'b0;
      illegal_o     <= 1'b0;
      alu_op1_o     <= '0;
      alu_op2_sel_o <= 1'b0;
      alu_op2_o     <= '0;
      alu_op2_imm_o <= '0;
      alu_func_o    <= ALU_ADD;
      rd_o          <= '0;
      pc_o          <= '0;
    end else begin
      illegal_o <= 1'b0;
      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (load) begin
        valid_o       <= is_legal;
        illegal_o     <= !is_legal;
        alu_op1_o     <= dec_op1;
        alu_op2_sel_o <= dec_sel;
        alu_op2_o     <= rf_rdata2_i;
        alu_op2_imm_o <= dec_imm;
        alu_func_o    <= dec_func;
        rd_o          <= is_legal ? rd : '0;
        pc_o          <= pc_i;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
